// File: rtl/parking_pkg.sv
// Shared constants and helpers for the parking-lot controller.
// Statistics outputs are enabled by defining PARKING_STATS_EN.
package parking_pkg;

  localparam int DEF_NUM_SLOTS = 16;
  localparam int STATS_W       = 32;

  function automatic int slot_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/parking_lot_ctrl_if.sv
// Event and status bundle between gate logic, controller and display.
// Carries total_entries/peak_count only when PARKING_STATS_EN is defined.
interface parking_lot_ctrl_if
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS
);
  localparam int SLOT_W = slot_w(NUM_SLOTS);
  localparam int CNT_W  = cnt_w(NUM_SLOTS);

  logic              arrive_req;
  logic              depart_valid;
  logic [SLOT_W-1:0] depart_slot;
  logic              arrive_grant;
  logic [SLOT_W-1:0] grant_slot;
  logic              arrive_reject;
  logic              depart_err;
  logic [NUM_SLOTS-1:0] slots;
  logic [CNT_W-1:0]  occ_count;
  logic              all_full;
  logic              any_free;
  logic              almost_full;
`ifdef PARKING_STATS_EN
  logic [STATS_W-1:0] total_entries;
  logic [CNT_W-1:0]   peak_count;

  modport master (
    output arrive_req, depart_valid, depart_slot,
    input  arrive_grant, grant_slot, arrive_reject,
    input  depart_err, slots, occ_count,
    input  all_full, any_free, almost_full,
    input  total_entries, peak_count
  );
  modport slave (
    input  arrive_req, depart_valid, depart_slot,
    output arrive_grant, grant_slot, arrive_reject,
    output depart_err, slots, occ_count,
    output all_full, any_free, almost_full,
    output total_entries, peak_count
  );
`else
  modport master (
    output arrive_req, depart_valid, depart_slot,
    input  arrive_grant, grant_slot, arrive_reject,
    input  depart_err, slots, occ_count,
    input  all_full, any_free, almost_full
  );
  modport slave (
    input  arrive_req, depart_valid, depart_slot,
    output arrive_grant, grant_slot, arrive_reject,
    output depart_err, slots, occ_count,
    output all_full, any_free, almost_full
  );
`endif

endinterface

// File: rtl/parking_free_finder.sv
// Lowest-index free slot finder over the occupancy map.
module parking_free_finder
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  localparam int SLOT_W = slot_w(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] map_i,
  output logic                 found_o,
  output logic [SLOT_W-1:0]    index_o
);

  // Scan downwards so the lowest zero bit wins.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!map_i[i]) begin
        found_o = 1'b1;
        index_o = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Parking-lot controller: owns the occupancy map, grants and releases slots.
// Define PARKING_STATS_EN to add total_entries and peak_count outputs.
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS      = DEF_NUM_SLOTS,
  parameter int ALMOST_FULL_TH = NUM_SLOTS - 2
) (
  input logic         clk,
  input logic         rst_n,
  parking_lot_ctrl_if.slave bus
);

  localparam int SLOT_W = slot_w(NUM_SLOTS);
  localparam int CNT_W  = cnt_w(NUM_SLOTS);
  localparam logic AF_RST = (ALMOST_FULL_TH == 0);

  logic [NUM_SLOTS-1:0] slots_q, slots_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [SLOT_W-1:0]    gslot_q;
  logic                 grant_q, reject_q, err_q;
  logic                 full_q, free_q, afull_q;

  logic              found;
  logic [SLOT_W-1:0] free_idx;
  logic              grant, reject, dep_in, dep_ok;

  parking_free_finder #(.NUM_SLOTS(NUM_SLOTS)) u_finder (
    .map_i   (slots_q),
    .found_o (found),
    .index_o (free_idx)
  );

  // Events are judged against the pre-edge map, so a slot freed
  // this cycle cannot be handed out until the next one.
  always_comb begin
    grant   = bus.arrive_req & found;
    reject  = bus.arrive_req & ~found;
    dep_in  = int'(bus.depart_slot) < NUM_SLOTS;
    dep_ok  = bus.depart_valid & dep_in
            & slots_q[bus.depart_slot];
    slots_d = slots_q;
    if (grant)
      slots_d[free_idx] = 1'b1;
    if (dep_ok)
      slots_d[bus.depart_slot] = 1'b0;
    count_d = count_q + CNT_W'(grant)
            - CNT_W'(dep_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q  <= '0;
      count_q  <= '0;
      gslot_q  <= '0;
      grant_q  <= 1'b0;
      reject_q <= 1'b0;
      err_q    <= 1'b0;
      full_q   <= 1'b0;
      free_q   <= 1'b1;
      afull_q  <= AF_RST;
    end else begin
      slots_q  <= slots_d;
      count_q  <= count_d;
      grant_q  <= grant;
      reject_q <= reject;
      err_q    <= bus.depart_valid & ~dep_ok;
      full_q   <= int'(count_d) == NUM_SLOTS;
      free_q   <= int'(count_d) != NUM_SLOTS;
      afull_q  <= int'(count_d) >= ALMOST_FULL_TH;
      if (grant)
        gslot_q <= free_idx;
    end
  end

  assign bus.slots         = slots_q;
  assign bus.occ_count     = count_q;
  assign bus.grant_slot    = gslot_q;
  assign bus.arrive_grant  = grant_q;
  assign bus.arrive_reject = reject_q;
  assign bus.depart_err    = err_q;
  assign bus.all_full      = full_q;
  assign bus.any_free      = free_q;
  assign bus.almost_full   = afull_q;

`ifdef PARKING_STATS_EN
  logic [STATS_W-1:0] total_q;
  logic [CNT_W-1:0]   peak_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      peak_q  <= '0;
    end else begin
      if (grant && total_q != '1)
        total_q <= total_q + 1'b1;
      if (count_d > peak_q)
        peak_q <= count_d;
    end
  end

  assign bus.total_entries = total_q;
  assign bus.peak_count    = peak_q;
`endif

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed self-checking bench for parking_lot_ctrl.
// Stats checks run only when PARKING_STATS_EN is defined.
module tb_parking_lot_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  parking_lot_ctrl_if #(.NUM_SLOTS(16)) bus ();
  parking_lot_ctrl_if #(.NUM_SLOTS(10)) bus10 ();

  parking_lot_ctrl #(.NUM_SLOTS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  parking_lot_ctrl #(.NUM_SLOTS(10)) dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus10.slave)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.arrive_req     = 1'b0;
    bus.depart_valid   = 1'b0;
    bus.depart_slot    = '0;
    bus10.arrive_req   = 1'b0;
    bus10.depart_valid = 1'b0;
    bus10.depart_slot  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    nvec++;
    if (bus.slots !== 16'h0 || bus.occ_count !== 5'd0) begin
      nerr++;
      $display("FAIL rst_map got %h/%0d exp 0000/0",
               bus.slots, bus.occ_count);
    end
    nvec++;
    if ({bus.all_full, bus.any_free, bus.almost_full}
        !== 3'b010) begin
      nerr++;
      $display("FAIL rst_flags got %b exp 010",
               {bus.all_full, bus.any_free, bus.almost_full});
    end
    nvec++;
    if ({bus.arrive_grant, bus.arrive_reject, bus.depart_err}
        !== 3'b000 || bus.grant_slot !== 4'd0) begin
      nerr++;
      $display("FAIL rst_pulses got %b/%0d exp 000/0",
               {bus.arrive_grant, bus.arrive_reject,
                bus.depart_err}, bus.grant_slot);
    end
  endtask

  task automatic test_fill();
    bus.arrive_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      nvec++;
      if (bus.arrive_grant !== 1'b1 ||
          bus.grant_slot !== 4'(i) ||
          bus.occ_count !== 5'(i + 1)) begin
        nerr++;
        $display("FAIL fill_%0d got g=%b s=%0d c=%0d exp 1/%0d/%0d",
                 i, bus.arrive_grant, bus.grant_slot,
                 bus.occ_count, i, i + 1);
      end
      nvec++;
      if (bus.almost_full !== (i + 1 >= 14)) begin
        nerr++;
        $display("FAIL fill_af_%0d got %b exp %b",
                 i, bus.almost_full, (i + 1 >= 14));
      end
    end
    bus.arrive_req = 1'b0;
    nvec++;
    if (bus.slots !== 16'hFFFF || bus.all_full !== 1'b1 ||
        bus.any_free !== 1'b0) begin
      nerr++;
      $display("FAIL fill_end got %h f=%b a=%b exp FFFF/1/0",
               bus.slots, bus.all_full, bus.any_free);
    end
  endtask

  task automatic test_reject();
    bus.arrive_req = 1'b1;
    step();
    bus.arrive_req = 1'b0;
    nvec++;
    if (bus.arrive_reject !== 1'b1 || bus.arrive_grant !== 1'b0 ||
        bus.slots !== 16'hFFFF || bus.occ_count !== 5'd16) begin
      nerr++;
      $display("FAIL reject got r=%b g=%b %h/%0d exp 1/0/FFFF/16",
               bus.arrive_reject, bus.arrive_grant,
               bus.slots, bus.occ_count);
    end
    bus.depart_valid = 1'b1;
    bus.depart_slot  = 4'd5;
    step();
    bus.depart_valid = 1'b0;
    nvec++;
    if (bus.slots !== 16'hFFDF || bus.occ_count !== 5'd15 ||
        bus.arrive_reject !== 1'b0 || bus.depart_err !== 1'b0 ||
        bus.all_full !== 1'b0 || bus.any_free !== 1'b1) begin
      nerr++;
      $display("FAIL depart5 got %h/%0d r=%b e=%b f=%b exp FFDF/15/0/0/0",
               bus.slots, bus.occ_count, bus.arrive_reject,
               bus.depart_err, bus.all_full);
    end
    bus.arrive_req = 1'b1;
    step();
    bus.arrive_req = 1'b0;
    nvec++;
    if (bus.arrive_grant !== 1'b1 || bus.grant_slot !== 4'd5 ||
        bus.slots !== 16'hFFFF) begin
      nerr++;
      $display("FAIL regrant got g=%b s=%0d %h exp 1/5/FFFF",
               bus.arrive_grant, bus.grant_slot, bus.slots);
    end
  endtask

  task automatic test_simul_full();
    bus.arrive_req   = 1'b1;
    bus.depart_valid = 1'b1;
    bus.depart_slot  = 4'd3;
    step();
    idle();
    nvec++;
    if (bus.arrive_reject !== 1'b1 || bus.arrive_grant !== 1'b0 ||
        bus.slots !== 16'hFFF7 || bus.occ_count !== 5'd15 ||
        bus.grant_slot !== 4'd5) begin
      nerr++;
      $display("FAIL simul_full got r=%b g=%b %h/%0d s=%0d exp 1/0/FFF7/15/5",
               bus.arrive_reject, bus.arrive_grant,
               bus.slots, bus.occ_count, bus.grant_slot);
    end
  endtask

  task automatic test_simul_grant();
    do_reset();
    bus.arrive_req = 1'b1;
    step();
    bus.arrive_req   = 1'b1;
    bus.depart_valid = 1'b1;
    bus.depart_slot  = 4'd0;
    step();
    idle();
    nvec++;
    if (bus.arrive_grant !== 1'b1 || bus.grant_slot !== 4'd1 ||
        bus.slots !== 16'h0002 || bus.occ_count !== 5'd1) begin
      nerr++;
      $display("FAIL simul_grant got g=%b s=%0d %h/%0d exp 1/1/0002/1",
               bus.arrive_grant, bus.grant_slot,
               bus.slots, bus.occ_count);
    end
  endtask

  task automatic test_depart_err();
    bus.depart_valid = 1'b1;
    bus.depart_slot  = 4'd7;
    bus10.depart_valid = 1'b1;
    bus10.depart_slot  = 4'd12;
    step();
    idle();
    nvec++;
    if (bus.depart_err !== 1'b1 || bus.slots !== 16'h0002 ||
        bus.occ_count !== 5'd1) begin
      nerr++;
      $display("FAIL err_free got e=%b %h/%0d exp 1/0002/1",
               bus.depart_err, bus.slots, bus.occ_count);
    end
    nvec++;
    if (bus10.depart_err !== 1'b1 || bus10.slots !== 10'h0 ||
        bus10.occ_count !== 4'd0) begin
      nerr++;
      $display("FAIL err_range got e=%b %h/%0d exp 1/000/0",
               bus10.depart_err, bus10.slots, bus10.occ_count);
    end
    step();
    nvec++;
    if (bus.depart_err !== 1'b0 || bus10.depart_err !== 1'b0) begin
      nerr++;
      $display("FAIL err_pulse got %b%b exp 00",
               bus.depart_err, bus10.depart_err);
    end
  endtask

  task automatic test_async_reset();
    bus.arrive_req = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (bus.arrive_grant !== 1'b0 || bus.slots !== 16'h0 ||
        bus.occ_count !== 5'd0 || bus.any_free !== 1'b1 ||
        bus.grant_slot !== 4'd0) begin
      nerr++;
      $display("FAIL async_rst got g=%b %h/%0d a=%b s=%0d exp 0/0000/0/1/0",
               bus.arrive_grant, bus.slots, bus.occ_count,
               bus.any_free, bus.grant_slot);
    end
    idle();
    step();
    rst_n = 1'b1;
  endtask

`ifdef PARKING_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.arrive_req = 1'b1;
    repeat (3) step();
    idle();
    bus.depart_valid = 1'b1;
    bus.depart_slot  = 4'd0;
    step();
    bus.depart_slot  = 4'd1;
    step();
    idle();
    bus.arrive_req = 1'b1;
    step();
    idle();
    nvec++;
    if (bus.total_entries !== 32'd4 || bus.peak_count !== 5'd3 ||
        bus.slots !== 16'h0005) begin
      nerr++;
      $display("FAIL stats got t=%0d p=%0d %h exp 4/3/0005",
               bus.total_entries, bus.peak_count, bus.slots);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (bus.total_entries !== 32'd0 || bus.peak_count !== 5'd0) begin
      nerr++;
      $display("FAIL stats_rst got t=%0d p=%0d exp 0/0",
               bus.total_entries, bus.peak_count);
    end
    step();
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    idle();
    step();
    test_reset();
    step();
    rst_n = 1'b1;
    test_fill();
    test_reject();
    test_simul_full();
    test_simul_grant();
    test_depart_err();
    test_async_reset();
    test_reset();
`ifdef PARKING_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
